// File: rtl/board_collapse.sv
// Line-clear board: DEPTH rows of WIDTH cells with merge-writes and a
// scan/shift pass that removes full rows. Optional macro: BOARD_TOTAL_LINES_EN.
module board_collapse #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 12,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_row,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear_start,
  input  logic [AW-1:0]    rd_row,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    lines_cleared,
  output logic [15:0]      total_lines
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_rows [DEPTH];
  logic [AW-1:0]    r_ptr;
  logic [CW-1:0]    r_lines;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_row_full;
  logic             w_start;

  assign w_wr_ok    = (r_state == S_IDLE) && wr_en && ({1'b0, wr_row} < DEPTH_C);
  assign w_rd_ok    = ({1'b0, rd_row} < DEPTH_C);
  assign w_row_full = &r_rows[r_ptr];
  assign w_start    = (r_state == S_IDLE) && clear_start;

  assign rd_data       = w_rd_ok ? r_rows[rd_row] : '0;
  assign busy          = (r_state == S_SCAN) || (r_state == S_SHIFT);
  assign done          = (r_state == S_DONE);
  assign lines_cleared = r_lines;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // A full row costs one SCAN plus one SHIFT; the pointer then re-examines
  // the row that dropped into its place, giving DEPTH+2k busy cycles.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (clear_start) w_state_nx = S_SCAN;
      S_SCAN: begin
        if (w_row_full)               w_state_nx = S_SHIFT;
        else if (r_ptr == LAST_PTR)   w_state_nx = S_DONE;
      end
      S_SHIFT: w_state_nx = S_SCAN;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_lines <= '0;
    end else if (w_start) begin
      r_ptr   <= '0;
      r_lines <= '0;
    end else if (r_state == S_SCAN && !w_row_full && r_ptr != LAST_PTR) begin
      r_ptr   <= r_ptr + AW'(1);
    end else if (r_state == S_SHIFT) begin
      r_lines <= r_lines + CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_rows[i] <= '0;
    end else if (r_state == S_SHIFT) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(r_ptr)) r_rows[i] <= r_rows[i + 1];
      end
      r_rows[DEPTH-1] <= '0;
    end else if (w_wr_ok) begin
      r_rows[wr_row] <= r_rows[wr_row] | wr_data;
    end
  end

`ifdef BOARD_TOTAL_LINES_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [15:0] r_total;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_total <= '0;
    end else if (r_state == S_DONE) begin
      r_total <= sat_add16(r_total, r_lines);
    end
  end

  assign total_lines = r_total;
`else
  assign total_lines = '0;
`endif

endmodule

// File: tb/tb_board_collapse.sv
// Bench for board_collapse: a row-list model predicts each pass outcome and
// its busy length; literal expectations pin the model on directed scenarios.
module tb_board_collapse;

  localparam int W  = 10;
  localparam int D  = 12;
  localparam int AW = 4;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_row = '0;
  logic [W-1:0]  wr_data = '0;
  logic          clear_start = 1'b0;
  logic [AW-1:0] rd_row = '0;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] lines_cleared;
  logic [15:0]   total_lines;

  always #5 Clk = ~Clk;

  board_collapse #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .clear_start(clear_start), .rd_row(rd_row), .rd_data(rd_data), .busy(busy),
    .done(done), .lines_cleared(lines_cleared), .total_lines(total_lines)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] m_rows [D];
  int m_busy_left = 0;
  bit m_done = 1'b0;
  int m_lc = 0;
  int m_pending = 0;
  int m_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_rows[i] = '0;
    m_busy_left = 0;
    m_done = 1'b0;
    m_lc = 0;
    m_pending = 0;
    m_total = 0;
  endtask

  // Collapse: keep non-full rows in bottom-up order, pad the top with empties.
  task automatic model_start();
    logic [W-1:0] kept[$];
    int k;
    kept = {};
    for (int i = 0; i < D; i++)
      if (m_rows[i] != {W{1'b1}}) kept.push_back(m_rows[i]);
    k = D - kept.size();
    for (int i = 0; i < D; i++) m_rows[i] = (i < kept.size()) ? kept[i] : '0;
    m_lc = k;
    m_pending = k;
    m_busy_left = D + 2 * k;
  endtask

  task automatic tick(input bit we, input int row, input logic [W-1:0] data, input bit cs);
    wr_en = we;
    wr_row = AW'(row);
    wr_data = data;
    clear_start = cs;
    @(posedge Clk);
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_done = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
`ifdef BOARD_TOTAL_LINES_EN
      m_total = (m_total + m_pending > 65535) ? 65535 : m_total + m_pending;
`endif
    end else begin
      if (we && row < D) m_rows[row] = m_rows[row] | data;
      if (cs) model_start();
    end
    #1;
    wr_en = 1'b0;
    clear_start = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      logic [W-1:0] e;
      check("busy", 32'(busy), 32'(m_busy_left > 0));
      check("done", 32'(done), 32'(m_done));
      if (m_busy_left == 0) begin
        e = (int'(rd_row) < D) ? m_rows[rd_row] : '0;
        check("lines_cleared", 32'(lines_cleared), 32'(m_lc));
        check("total_lines", 32'(total_lines), 32'(m_total));
        check("rd_data", 32'(rd_data), 32'(e));
      end
    end
  end

  task automatic read_row(input int r, output logic [W-1:0] d);
    rd_row = AW'(r);
    #1;
    d = rd_data;
  endtask

  task automatic sweep(input string tag, input int ra, input logic [W-1:0] va,
                       input int rb, input logic [W-1:0] vb);
    logic [W-1:0] d;
    logic [W-1:0] e;
    for (int r = 0; r < 16; r++) begin
      e = (r == ra) ? va : ((r == rb) ? vb : '0);
      read_row(r, d);
      check(tag, 32'(d), 32'(e));
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_pass(input bit we, input int row, input logic [W-1:0] data,
                          input int exp_busy, input int exp_lc, input bit noise);
    int cnt;
    int guard;
    tick(we, row, data, 1'b1);
    cnt = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 300) begin
      if (busy === 1'b1) cnt++;
      if (noise && guard == 3) tick(1'b1, 3, {W{1'b1}}, 1'b1);
      else tick(1'b0, 0, '0, 1'b0);
      guard++;
    end
    check("pass_done_seen", 32'(done), 32'd1);
    check("pass_busy_cycles", 32'(cnt), 32'(exp_busy));
    check("pass_lines_cleared", 32'(lines_cleared), 32'(exp_lc));
    tick(1'b0, 0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    int dcount;
    model_reset();

    // Reset state while reset is held low
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_total", 32'(total_lines), 32'd0);
    sweep("rst_board", -1, '0, -1, '0);
    @(negedge Clk);
    reset = 1'b1;
    @(posedge Clk);
    #1;
    chk_en = 1'b1;

    // Empty board pass
    tick(1'b0, 0, '0, 1'b0);
    run_pass(1'b0, 0, '0, 12, 0, 1'b0);

    // Merge-writes, out-of-range write and read
    tick(1'b1, 5, 10'h00F, 1'b0);
    tick(1'b1, 5, 10'h3F0, 1'b0);
    read_row(5, d);
    check("merge_row5", 32'(d), 32'h3FF);
    tick(1'b1, 12, 10'h3FF, 1'b0);
    tick(1'b1, 15, 10'h155, 1'b0);
    read_row(13, d);
    check("rd_row13_zero", 32'(d), 32'h0);
    sweep("after_oob_write", 5, 10'h3FF, -1, '0);
    run_pass(1'b0, 0, '0, 14, 1, 1'b0);
    sweep("after_row5_clear", -1, '0, -1, '0);

    // Two full rows under a partial row, with ignored write/start mid-pass
    tick(1'b1, 0, 10'h3FF, 1'b0);
    tick(1'b1, 1, 10'h3FF, 1'b0);
    tick(1'b1, 2, 10'h001, 1'b0);
    run_pass(1'b0, 0, '0, 16, 2, 1'b1);
    sweep("two_clear", 0, 10'h001, -1, '0);

    // Write in the same cycle as the accepted start
    run_pass(1'b1, 4, 10'h3FF, 14, 1, 1'b0);
    sweep("same_cycle_write", 0, 10'h001, -1, '0);

    // Whole board full
    for (int r = 0; r < D; r++) tick(1'b1, r, 10'h3FF, 1'b0);
    run_pass(1'b0, 0, '0, 36, 12, 1'b0);
    sweep("full_board", -1, '0, -1, '0);

    // Mixed pattern: full rows 0,2,3,11
    tick(1'b1, 0, 10'h3FF, 1'b0);
    tick(1'b1, 1, 10'h155, 1'b0);
    tick(1'b1, 2, 10'h3FF, 1'b0);
    tick(1'b1, 3, 10'h3FF, 1'b0);
    tick(1'b1, 4, 10'h2AA, 1'b0);
    tick(1'b1, 11, 10'h3FF, 1'b0);
    run_pass(1'b0, 0, '0, 20, 4, 1'b0);
    sweep("mixed", 0, 10'h155, 1, 10'h2AA);
    repeat (4) tick(1'b0, 0, '0, 1'b0);
    check("lines_hold", 32'(lines_cleared), 32'd4);
`ifndef BOARD_TOTAL_LINES_EN
    check("total_tied_zero", 32'(total_lines), 32'd0);
`endif

    // Reset asserted during the second SHIFT of a pass
    tick(1'b1, 0, 10'h3FF, 1'b0);
    tick(1'b1, 1, 10'h3FF, 1'b0);
    tick(1'b0, 0, '0, 1'b1);
    repeat (3) tick(1'b0, 0, '0, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_lines", 32'(lines_cleared), 32'd1);
    #2;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_lines", 32'(lines_cleared), 32'd0);
    sweep("midrst_board", -1, '0, -1, '0);
    model_reset();
    @(negedge Clk);
    reset = 1'b1;
    @(posedge Clk);
    #1;
    chk_en = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 0, '0, 1'b0);
      if (done === 1'b1) dcount++;
    end
    check("no_done_after_rst", 32'(dcount), 32'd0);

    // Two passes clearing 2 then 3 rows
    tick(1'b1, 0, 10'h3FF, 1'b0);
    tick(1'b1, 1, 10'h3FF, 1'b0);
    run_pass(1'b0, 0, '0, 16, 2, 1'b0);
    for (int r = 0; r < 3; r++) tick(1'b1, r, 10'h3FF, 1'b0);
    run_pass(1'b0, 0, '0, 18, 3, 1'b0);
`ifdef BOARD_TOTAL_LINES_EN
    check("total_five", 32'(total_lines), 32'd5);
    force dut.r_total = 16'hFFFE;
    #1;
    release dut.r_total;
    m_total = 65534;
    for (int r = 0; r < 3; r++) tick(1'b1, r, 10'h3FF, 1'b0);
    run_pass(1'b0, 0, '0, 18, 3, 1'b0);
    check("total_saturate", 32'(total_lines), 32'hFFFF);
`else
    check("total_still_zero", 32'(total_lines), 32'd0);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/board_collapse.md
BOARD_COLLAPSE -- requirements
Module: board_collapse

Interface
REQ-001 SHALL have parameter WIDTH, default 10: columns per row, legal range 1-32.
REQ-002 SHALL have parameter DEPTH, default 12: rows in the board, legal range 2-64; row 0 = bottom, row DEPTH-1 = top.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port wr_en  input  1  merge-write strobe.
REQ-006 SHALL have port wr_row  input  clog2(DEPTH)  target row of the merge-write.
REQ-007 SHALL have port wr_data  input  WIDTH  cells to OR into the target row.
REQ-008 SHALL have port clear_start  input  1  single-cycle request to run a clear/collapse pass.
REQ-009 SHALL have port rd_row  input  clog2(DEPTH)  combinational read address.
REQ-010 SHALL have port rd_data  output  WIDTH  contents of row rd_row.
REQ-011 SHALL have port busy  output  1  high while a pass runs.
REQ-012 SHALL have port done  output  1  one-cycle pulse at the end of a pass.
REQ-013 SHALL have port lines_cleared  output  clog2(DEPTH+1)  count of rows removed by the last pass.
REQ-014 SHALL have port total_lines  output  16  cumulative cleared rows (see Configuration).

Function
REQ-015 SHALL store DEPTH x WIDTH cell bits.
REQ-016 SHALL, in IDLE with wr_en=1 and wr_row<DEPTH, set row[wr_row] <= row[wr_row] | wr_data at the next edge.
REQ-017 SHALL ignore wr_en when wr_row>=DEPTH or when busy=1.
REQ-018 SHALL drive rd_data = row[rd_row] combinationally, and all zeros for rd_row>=DEPTH.
REQ-019 SHALL implement FSM states IDLE, SCAN, SHIFT, DONE with scan pointer ptr.
REQ-020 SHALL, in IDLE with clear_start=1, go to SCAN with ptr=0 and lines_cleared=0; wr_en in the same cycle is still applied first.
REQ-021 SHALL ignore clear_start outside IDLE.
REQ-022 SHALL, in SCAN, go to SHIFT if row[ptr] is all ones.
REQ-023 SHALL, in SCAN with a non-full row, increment ptr; it SHALL go to DONE when ptr=DEPTH-1.
REQ-024 SHALL, in SHIFT, take one cycle with the following effects:
- row[i] <= row[i+1] for ptr<=i<DEPTH-1;
- row[DEPTH-1] <= 0;
- lines_cleared increments;
- return to SCAN with ptr unchanged.
REQ-025 SHALL assert busy=1 exactly in SCAN and SHIFT.
REQ-026 SHALL, in DONE, assert done=1 for one cycle and return to IDLE.
REQ-027 SHALL give a pass with k full rows exactly DEPTH+2k busy cycles, with done in the following cycle.
REQ-028 SHALL hold lines_cleared from DONE until the next accepted clear_start.
REQ-029 SHALL remove all rows in one pass when the whole board is full: k=DEPTH, board all zeros afterwards.

Reset
REQ-030 SHALL, while reset=0, immediately force the following regardless of Clk, including mid-pass:
- all cells 0;
- state IDLE, ptr 0;
- busy 0, done 0;
- lines_cleared 0, total_lines 0.
REQ-031 SHALL resume normal operation on the first rising edge of Clk after reset returns to 1.

Configuration
REQ-032 SHALL, with macro BOARD_TOTAL_LINES_EN defined, add lines_cleared to total_lines in the DONE cycle, saturating at 16'hFFFF.
REQ-033 SHALL, without BOARD_TOTAL_LINES_EN, tie total_lines to 0 and contain no accumulator logic.

Verification
REQ-034 SHALL cover: defaults, empty board, clear_start -> busy high 12 cycles, done on cycle 13, lines_cleared=0.
REQ-035 SHALL cover: write rows 0 and 1 with 10'h3FF, row 2 with 10'h001, start -> busy 16 cycles, lines_cleared=2, row0=10'h001, rows 1-11 zero.
REQ-036 SHALL cover: all 12 rows full, start -> lines_cleared=12, busy 36 cycles, board all zeros.
REQ-037 SHALL cover: write row 5 with 10'h00F then 10'h3F0 -> rd_data(5)=10'h3FF; wr_row=12 -> no change; rd_row=13 -> 0.
REQ-038 SHALL cover: reset=0 during SHIFT of a pass -> busy, done and lines_cleared 0 at once, rd_data=0 for all rows, no done pulse afterwards.
REQ-039 SHALL cover, with BOARD_TOTAL_LINES_EN: two passes clearing 2 and 3 rows -> total_lines=5; preload total_lines 16'hFFFE, clear 3 -> 16'hFFFF.
